decode_stage: RTL and testbench

DECODE_STAGE -- requirements
Module: decode_stage

---
 rtl/decode_stage_if.sv | 42 ++++
 rtl/decode_stage.sv | 163 ++++++++++++++++
 tb/tb_decode_stage.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/decode_stage_if.sv
// Fetch-to-execute handshake bundle around the decode stage.
// slave is the decode stage's view; master is the surrounding pipeline's view.
interface decode_stage_if #(
  parameter int unsigned XLEN = 32
) ();
   logic            in_valid;
   logic            in_ready;
   logic [31:0]     in_inst;
   logic [XLEN-1:0] in_pc;
   logic            flush;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] out_pc;
   logic            write_en;
   logic            mem_write_en;
   logic            mem_read_en;
   logic            alu_src1_from_pc;
   logic            alu_src2_from_imm;
   logic            branch_inst;
   logic            jump_inst;
   logic            illegal_inst;
   logic [4:0]      write_addr;
   logic [4:0]      read_addr1;
   logic [4:0]      read_addr2;
   logic [XLEN-1:0] immediate;
   logic [2:0]      funct3;
   logic [3:0]      alu_opcode;

   modport slave (
      input  in_valid, in_inst, in_pc, flush, out_ready,
      output in_ready, out_valid, out_pc, write_en, mem_write_en, mem_read_en,
             alu_src1_from_pc, alu_src2_from_imm, branch_inst, jump_inst, illegal_inst,
             write_addr, read_addr1, read_addr2, immediate, funct3, alu_opcode
   );

   modport master (
      output in_valid, in_inst, in_pc, flush, out_ready,
      input  in_ready, out_valid, out_pc, write_en, mem_write_en, mem_read_en,
             alu_src1_from_pc, alu_src2_from_imm, branch_inst, jump_inst, illegal_inst,
             write_addr, read_addr1, read_addr2, immediate, funct3, alu_opcode
   );
endinterface

// File: rtl/decode_stage.sv
// RV32I/RV64I base decode stage: combinational decode into a one-entry output register
// with valid/ready handshake, flush and synchronous reset.
module decode_stage #(
  parameter int unsigned XLEN = 32
) (
   input logic          clk,
   input logic          reset,
   decode_stage_if.slave bus
);

   localparam logic [6:0] OpcOpImm  = 7'b0010011;
   localparam logic [6:0] OpcOp     = 7'b0110011;
   localparam logic [6:0] OpcBranch = 7'b1100011;
   localparam logic [6:0] OpcStore  = 7'b0100011;
   localparam logic [6:0] OpcLoad   = 7'b0000011;
   localparam logic [6:0] OpcLui    = 7'b0110111;
   localparam logic [6:0] OpcAuipc  = 7'b0010111;
   localparam logic [6:0] OpcJal    = 7'b1101111;
   localparam logic [6:0] OpcJalr   = 7'b1100111;

   function automatic logic [XLEN-1:0] sext(input logic [31:0] v);
      logic [XLEN-1:0] r;
      r       = {XLEN{v[31]}};
      r[31:0] = v;
      return r;
   endfunction

   logic [31:0]     inst;
   logic [6:0]      opcode;
   logic [2:0]      f3;
   logic [31:0]     imm_i, imm_s, imm_b, imm_u, imm_j;
   logic            d_we, d_mw, d_mr, d_s1pc, d_s2imm, d_br, d_jmp, d_ill;
   logic [4:0]      d_rs1;
   logic [XLEN-1:0] d_imm;
   logic [3:0]      d_aop;
   logic            accept;

   assign inst   = bus.in_inst;
   assign opcode = inst[6:0];
   assign f3     = inst[14:12];
   assign imm_i  = {{20{inst[31]}}, inst[31:20]};
   assign imm_s  = {{20{inst[31]}}, inst[31:25], inst[11:7]};
   assign imm_b  = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
   assign imm_u  = {inst[31:12], 12'b0};
   assign imm_j  = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

   always_comb begin
      d_we    = 1'b0;
      d_mw    = 1'b0;
      d_mr    = 1'b0;
      d_s1pc  = 1'b0;
      d_s2imm = 1'b0;
      d_br    = 1'b0;
      d_jmp   = 1'b0;
      d_ill   = 1'b0;
      d_rs1   = inst[19:15];
      d_imm   = '0;
      d_aop   = 4'b0000;
      unique case (opcode)
         OpcOpImm: begin
            d_we    = 1'b1;
            d_s2imm = 1'b1;
            d_imm   = sext(imm_i);
            d_aop   = {inst[30] & (f3 == 3'b101), f3};
         end
         OpcOp: begin
            d_we  = 1'b1;
            d_aop = {inst[30], f3};
         end
         OpcBranch: begin
            d_br  = 1'b1;
            d_imm = sext(imm_b);
         end
         OpcStore: begin
            d_mw    = 1'b1;
            d_s2imm = 1'b1;
            d_imm   = sext(imm_s);
         end
         OpcLoad: begin
            d_we    = 1'b1;
            d_mr    = 1'b1;
            d_s2imm = 1'b1;
            d_imm   = sext(imm_i);
         end
         OpcLui: begin
            d_we    = 1'b1;
            d_s2imm = 1'b1;
            d_imm   = sext(imm_u);
            d_rs1   = 5'd0;
         end
         OpcAuipc: begin
            d_we    = 1'b1;
            d_s1pc  = 1'b1;
            d_s2imm = 1'b1;
            d_imm   = sext(imm_u);
         end
         OpcJal: begin
            d_we  = 1'b1;
            d_jmp = 1'b1;
            d_imm = sext(imm_j);
         end
         OpcJalr: begin
            if (f3 == 3'b000) begin
               d_we    = 1'b1;
               d_jmp   = 1'b1;
               d_s2imm = 1'b1;
               d_imm   = sext(imm_i);
            end else begin
               d_ill = 1'b1;
            end
         end
         default: d_ill = 1'b1;
      endcase
      // x0 is never a write target
      if (inst[11:7] == 5'd0) d_we = 1'b0;
   end

   assign bus.in_ready = (!bus.out_valid || bus.out_ready) && !reset;
   assign accept       = bus.in_valid && bus.in_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         bus.out_valid         <= 1'b0;
         bus.out_pc            <= '0;
         bus.write_en          <= 1'b0;
         bus.mem_write_en      <= 1'b0;
         bus.mem_read_en       <= 1'b0;
         bus.alu_src1_from_pc  <= 1'b0;
         bus.alu_src2_from_imm <= 1'b0;
         bus.branch_inst       <= 1'b0;
         bus.jump_inst         <= 1'b0;
         bus.illegal_inst      <= 1'b0;
         bus.write_addr        <= 5'd0;
         bus.read_addr1        <= 5'd0;
         bus.read_addr2        <= 5'd0;
         bus.immediate         <= '0;
         bus.funct3            <= 3'd0;
         bus.alu_opcode        <= 4'd0;
      end else if (bus.flush) begin
         bus.out_valid <= 1'b0;
      end else if (accept) begin
         bus.out_valid         <= 1'b1;
         bus.out_pc            <= bus.in_pc;
         bus.write_en          <= d_we;
         bus.mem_write_en      <= d_mw;
         bus.mem_read_en       <= d_mr;
         bus.alu_src1_from_pc  <= d_s1pc;
         bus.alu_src2_from_imm <= d_s2imm;
         bus.branch_inst       <= d_br;
         bus.jump_inst         <= d_jmp;
         bus.illegal_inst      <= d_ill;
         bus.write_addr        <= inst[11:7];
         bus.read_addr1        <= d_rs1;
         bus.read_addr2        <= inst[24:20];
         bus.immediate         <= d_imm;
         bus.funct3            <= f3;
         bus.alu_opcode        <= d_aop;
      end else if (bus.out_ready) begin
         bus.out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage at XLEN=64: directed scenarios plus a randomized
// handshake stream scored against a behavioural decode model.
module tb_decode_stage;
   localparam int unsigned XLEN = 64;

   logic clk = 1'b0;
   logic reset;

   decode_stage_if #(.XLEN(XLEN)) bus ();
   decode_stage #(.XLEN(XLEN)) dut (.clk(clk), .reset(reset), .bus(bus));

   always #5 clk = ~clk;

   typedef struct packed {
      logic [63:0] pc;
      logic        we, mw, mr, s1pc, s2imm, br, jmp, ill;
      logic [4:0]  rd, rs1, rs2;
      logic [63:0] imm;
      logic [2:0]  f3;
      logic [3:0]  aop;
   } bundle_t;

   bundle_t act;
   always_comb begin
      act       = '0;
      act.pc    = bus.out_pc;
      act.we    = bus.write_en;
      act.mw    = bus.mem_write_en;
      act.mr    = bus.mem_read_en;
      act.s1pc  = bus.alu_src1_from_pc;
      act.s2imm = bus.alu_src2_from_imm;
      act.br    = bus.branch_inst;
      act.jmp   = bus.jump_inst;
      act.ill   = bus.illegal_inst;
      act.rd    = bus.write_addr;
      act.rs1   = bus.read_addr1;
      act.rs2   = bus.read_addr2;
      act.imm   = bus.immediate;
      act.f3    = bus.funct3;
      act.aop   = bus.alu_opcode;
   end

   int n_checks = 0;
   int n_fail   = 0;

   bit      m_valid;
   bit      m_known;
   bundle_t m_b;

   function automatic bundle_t ref_decode(input logic [31:0] inst, input logic [63:0] pc);
      bundle_t b;
      longint  ii, is, ib, iu, ij;
      ii = longint'($signed(inst[31:20]));
      is = longint'($signed({inst[31:25], inst[11:7]}));
      ib = longint'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
      iu = longint'($signed(inst[31:12])) * 4096;
      ij = longint'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));
      b     = '0;
      b.pc  = pc;
      b.rd  = inst[11:7];
      b.rs1 = inst[19:15];
      b.rs2 = inst[24:20];
      b.f3  = inst[14:12];
      case (inst[6:0])
         7'h13: begin
            b.we = 1; b.s2imm = 1; b.imm = ii;
            b.aop = (b.f3 == 3'd5) ? {inst[30], b.f3} : {1'b0, b.f3};
         end
         7'h33: begin b.we = 1; b.aop = {inst[30], b.f3}; end
         7'h63: begin b.br = 1; b.imm = ib; end
         7'h23: begin b.mw = 1; b.s2imm = 1; b.imm = is; end
         7'h03: begin b.we = 1; b.mr = 1; b.s2imm = 1; b.imm = ii; end
         7'h37: begin b.we = 1; b.s2imm = 1; b.imm = iu; b.rs1 = 0; end
         7'h17: begin b.we = 1; b.s1pc = 1; b.s2imm = 1; b.imm = iu; end
         7'h6f: begin b.we = 1; b.jmp = 1; b.imm = ij; end
         7'h67: begin
            if (b.f3 == 3'd0) begin b.we = 1; b.jmp = 1; b.s2imm = 1; b.imm = ii; end
            else b.ill = 1;
         end
         default: b.ill = 1;
      endcase
      if (b.rd == 5'd0) b.we = 0;
      return b;
   endfunction

   function automatic logic [31:0] rand_inst();
      logic [31:0] w;
      int          k;
      w = $urandom;
      k = $urandom_range(0, 10);
      case (k)
         0: w[6:0] = 7'h13;
         1: w[6:0] = 7'h33;
         2: w[6:0] = 7'h63;
         3: w[6:0] = 7'h23;
         4: w[6:0] = 7'h03;
         5: w[6:0] = 7'h37;
         6: w[6:0] = 7'h17;
         7: w[6:0] = 7'h6f;
         8: begin
            w[6:0] = 7'h67;
            if ($urandom_range(0, 3) != 0) w[14:12] = 3'd0;
         end
         default: ;
      endcase
      return w;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1; bus.in_valid = 1; bus.in_inst = 32'hFFF00293; bus.in_pc = 64'h40;
      bus.out_ready = 1; bus.flush = 0;
      #1;
      n_checks++;
      if (bus.in_ready !== 1'b0) $display("FAIL reset_in_ready: got %b expected 0", bus.in_ready);
      if (bus.in_ready !== 1'b0) n_fail++;
      repeat (2) tick();
      n_checks++;
      if (bus.out_valid !== 1'b0) begin
         n_fail++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid);
      end
      n_checks++;
      if (act !== '0) begin n_fail++; $display("FAIL reset_outputs: got %h expected 0", act); end
   endtask

   task automatic test_addi();
      reset = 0; bus.in_valid = 1; bus.in_inst = 32'hFFF00293; bus.in_pc = 64'h1000;
      bus.out_ready = 1;
      #1;
      n_checks++;
      if (bus.in_ready !== 1'b1) begin
         n_fail++; $display("FAIL addi_in_ready: got %b expected 1", bus.in_ready);
      end
      tick();
      bus.in_valid = 0;
      n_checks++;
      if ({bus.out_valid, bus.write_en, bus.write_addr, bus.alu_opcode} !== {1'b1, 1'b1, 5'd5, 4'd0})
         begin
         n_fail++;
         $display("FAIL addi_ctrl: got v=%b we=%b rd=%0d aop=%h expected v=1 we=1 rd=5 aop=0",
                  bus.out_valid, bus.write_en, bus.write_addr, bus.alu_opcode);
      end
      n_checks++;
      if (bus.immediate !== 64'hFFFF_FFFF_FFFF_FFFF || bus.out_pc !== 64'h1000) begin
         n_fail++;
         $display("FAIL addi_imm_pc: got imm=%h pc=%h expected imm=all ones pc=1000",
                  bus.immediate, bus.out_pc);
      end
   endtask

   task automatic test_stall();
      bus.out_ready = 0; bus.in_valid = 1; bus.in_inst = 32'h002081B3; bus.in_pc = 64'h2000;
      for (int i = 0; i < 3; i++) begin
         #1;
         n_checks++;
         if (bus.in_ready !== 1'b0) begin
            n_fail++; $display("FAIL stall_in_ready: got %b expected 0", bus.in_ready);
         end
         tick();
         n_checks++;
         if (bus.out_valid !== 1'b1 || bus.out_pc !== 64'h1000 || bus.write_addr !== 5'd5 ||
             bus.immediate !== 64'hFFFF_FFFF_FFFF_FFFF) begin
            n_fail++;
            $display("FAIL stall_hold: got v=%b pc=%h rd=%0d imm=%h expected v=1 pc=1000 rd=5",
                     bus.out_valid, bus.out_pc, bus.write_addr, bus.immediate);
         end
      end
      bus.out_ready = 1;
      #1;
      n_checks++;
      if (bus.in_ready !== 1'b1) begin
         n_fail++; $display("FAIL stall_release: got %b expected 1", bus.in_ready);
      end
      tick();
      bus.in_valid = 0;
      n_checks++;
      if ({bus.out_valid, bus.write_en, bus.write_addr, bus.read_addr1, bus.read_addr2} !==
          {1'b1, 1'b1, 5'd3, 5'd1, 5'd2} || bus.out_pc !== 64'h2000) begin
         n_fail++;
         $display("FAIL stall_second: got v=%b we=%b rd=%0d rs1=%0d rs2=%0d pc=%h expected 1 1 3 1 2 2000",
                  bus.out_valid, bus.write_en, bus.write_addr, bus.read_addr1, bus.read_addr2,
                  bus.out_pc);
      end
   endtask

   task automatic test_flush();
      bus.out_ready = 1; bus.in_valid = 1; bus.flush = 1; bus.in_inst = 32'hFFF00293;
      tick();
      bus.flush = 0; bus.in_valid = 0;
      n_checks++;
      if (bus.out_valid !== 1'b0) begin
         n_fail++; $display("FAIL flush_beats_accept: got %b expected 0", bus.out_valid);
      end
   endtask

   task automatic test_lui64();
      bus.out_ready = 1; bus.in_valid = 1; bus.in_inst = 32'h800000B7; bus.in_pc = 64'h3000;
      tick();
      bus.in_valid = 0;
      n_checks++;
      if (bus.immediate !== 64'hFFFF_FFFF_8000_0000 || bus.read_addr1 !== 5'd0 ||
          bus.write_en !== 1'b1 || bus.alu_src2_from_imm !== 1'b1) begin
         n_fail++;
         $display("FAIL lui64: got imm=%h rs1=%0d we=%b s2imm=%b expected ffffffff80000000 0 1 1",
                  bus.immediate, bus.read_addr1, bus.write_en, bus.alu_src2_from_imm);
      end
   endtask

   task automatic test_illegal();
      bus.out_ready = 1; bus.in_valid = 1; bus.in_inst = 32'h0000_0000;
      tick();
      n_checks++;
      if (bus.illegal_inst !== 1'b1 || bus.immediate !== 64'd0 || bus.alu_opcode !== 4'd0 ||
          {bus.write_en, bus.mem_write_en, bus.mem_read_en, bus.alu_src1_from_pc,
           bus.alu_src2_from_imm, bus.branch_inst, bus.jump_inst} !== 7'd0) begin
         n_fail++;
         $display("FAIL illegal_zero: got ill=%b imm=%h flags=%b expected ill=1 imm=0 flags=0",
                  bus.illegal_inst, bus.immediate,
                  {bus.write_en, bus.mem_write_en, bus.mem_read_en, bus.alu_src1_from_pc,
                   bus.alu_src2_from_imm, bus.branch_inst, bus.jump_inst});
      end
      bus.in_inst = 32'h00208033;
      tick();
      bus.in_valid = 0;
      n_checks++;
      if ({bus.out_valid, bus.illegal_inst, bus.write_en} !== 3'b100) begin
         n_fail++;
         $display("FAIL add_x0: got v=%b ill=%b we=%b expected v=1 ill=0 we=0",
                  bus.out_valid, bus.illegal_inst, bus.write_en);
      end
   endtask

   task automatic test_reset_mid();
      bus.out_ready = 1; bus.in_valid = 1; bus.in_inst = 32'hFFF00293; bus.in_pc = 64'h4000;
      tick();
      bus.out_ready = 0; bus.in_inst = 32'h002081B3; reset = 1;
      #1;
      n_checks++;
      if (bus.in_ready !== 1'b0) begin
         n_fail++; $display("FAIL midreset_in_ready: got %b expected 0", bus.in_ready);
      end
      tick();
      n_checks++;
      if (bus.out_valid !== 1'b0 || act !== '0) begin
         n_fail++;
         $display("FAIL midreset_drop: got v=%b bundle=%h expected v=0 bundle=0", bus.out_valid, act);
      end
      reset = 0; bus.out_ready = 1; bus.in_inst = 32'hFFF00293;
      #1;
      n_checks++;
      if (bus.in_ready !== 1'b1) begin
         n_fail++; $display("FAIL postreset_in_ready: got %b expected 1", bus.in_ready);
      end
      tick();
      bus.in_valid = 0;
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.write_addr !== 5'd5) begin
         n_fail++;
         $display("FAIL postreset_accept: got v=%b rd=%0d expected v=1 rd=5",
                  bus.out_valid, bus.write_addr);
      end
   endtask

   task automatic test_random();
      bit exp_rdy;
      reset = 1; bus.flush = 0; bus.in_valid = 0;
      tick();
      m_valid = 0; m_known = 1; m_b = '0;
      for (int i = 0; i < 500; i++) begin
         reset         = ($urandom_range(0, 31) == 0);
         bus.flush     = ($urandom_range(0, 11) == 0);
         bus.in_valid  = ($urandom_range(0, 9) < 7);
         bus.out_ready = ($urandom_range(0, 9) < 6);
         bus.in_inst   = rand_inst();
         bus.in_pc     = {$urandom, $urandom};
         #1;
         exp_rdy = (!m_valid || bus.out_ready) && !reset;
         n_checks++;
         if (bus.in_ready !== exp_rdy) begin
            n_fail++; $display("FAIL rnd_in_ready[%0d]: got %b expected %b", i, bus.in_ready, exp_rdy);
         end
         @(posedge clk);
         if (reset) begin
            m_valid = 0; m_known = 1; m_b = '0;
         end else if (bus.flush) begin
            m_valid = 0; m_known = 0;
         end else if (bus.in_valid && exp_rdy) begin
            m_valid = 1; m_known = 1; m_b = ref_decode(bus.in_inst, bus.in_pc);
         end else if (bus.out_ready) begin
            m_valid = 0; m_known = 0;
         end
         #1;
         n_checks++;
         if (bus.out_valid !== m_valid) begin
            n_fail++;
            $display("FAIL rnd_out_valid[%0d]: got %b expected %b", i, bus.out_valid, m_valid);
         end
         if (m_known) begin
            n_checks++;
            if (act !== m_b) begin
               n_fail++; $display("FAIL rnd_bundle[%0d]: got %h expected %h", i, act, m_b);
            end
         end
      end
      reset = 0; bus.flush = 0; bus.in_valid = 0;
   endtask

   initial begin
      test_reset();
      test_addi();
      test_stall();
      test_flush();
      test_lui64();
      test_illegal();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
